// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline definitions: register-file geometry and the MEM/WB bundle
// that the memory stage produces and the writeback stage consumes.
package writeback_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     aluout;
        logic                  regwrite;
    } mw_bus_t;

    // A write only retires when enabled and not aimed at the hardwired r0.
    function automatic logic is_commit(mw_bus_t mw);
        return mw.regwrite && (mw.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback-stage bus: MEM/WB inputs, decode read ports, WB echo and the
// retire counter. The pipeline side is the master, the register file the slave.
interface writeback_regfile_if #(
    parameter int DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int AW     = writeback_regfile_pkg::REG_ADDR_W
);
    logic [AW-1:0]     MW_RD;
    logic [DATA_W-1:0] MW_ALUout;
    logic              MW_RegWrite;
    logic [AW-1:0]     rs_addr;
    logic [AW-1:0]     rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [AW-1:0]     WB_RD;
    logic [DATA_W-1:0] WB_data;
    logic              WB_RegWrite;
    logic [31:0]       wb_count;

    modport master (
        output MW_RD, MW_ALUout, MW_RegWrite, rs_addr, rt_addr,
        input  rs_data, rt_data, WB_RD, WB_data, WB_RegWrite, wb_count
    );

    modport slave (
        input  MW_RD, MW_ALUout, MW_RegWrite, rs_addr, rt_addr,
        output rs_data, rt_data, WB_RD, WB_data, WB_RegWrite, wb_count
    );
endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// Two-read one-write register array with async clear and r0 held at zero.
// Reads are raw array contents; bypassing is the caller's job.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data
);
    logic [NREG-1:0][DATA_W-1:0] rf_q;
    logic [NREG-1:0][DATA_W-1:0] rf_d;

    // Next array contents: one entry updated per cycle, r0 never written.
    always_comb begin
        rf_d = rf_q;
        if (we && (waddr != '0)) begin
            rf_d[waddr] = wdata;
        end
    end

    // Array storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Raw read ports; r0 masked so it reads zero regardless of contents.
    always_comb begin
        ra_data = (ra_addr == '0) ? '0 : rf_q[ra_addr];
        rb_data = (rb_addr == '0) ? '0 : rf_q[rb_addr];
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits MEM/WB results into the register file, serves the
// decode read ports with same-cycle bypass, echoes the commit for WB->EX
// forwarding and counts retired writes.
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input logic               clk,
    input logic               rst,
    writeback_regfile_if.slave bus
);
    import writeback_regfile_pkg::*;

    localparam int AW = $clog2(NREG);

    mw_bus_t           mw;
    logic              commit;
    logic [DATA_W-1:0] rs_raw;
    logic [DATA_W-1:0] rt_raw;

    logic [AW-1:0]     wb_rd_q,        wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,      wb_data_d;
    logic              wb_regwrite_q,  wb_regwrite_d;
    logic [31:0]       wb_count_q,     wb_count_d;

    assign mw     = '{rd: bus.MW_RD, aluout: bus.MW_ALUout, regwrite: bus.MW_RegWrite};
    assign commit = is_commit(mw);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .waddr   (bus.MW_RD),
        .wdata   (bus.MW_ALUout),
        .ra_addr (bus.rs_addr),
        .ra_data (rs_raw),
        .rb_addr (bus.rt_addr),
        .rb_data (rt_raw)
    );

    // Read mux: r0 first, then the in-flight commit, then the array.
    // Held at zero during reset so a write presented in reset never shows.
    always_comb begin
        bus.rs_data = '0;
        bus.rt_data = '0;
        if (rst && (bus.rs_addr != '0)) begin
            bus.rs_data = (commit && (bus.MW_RD == bus.rs_addr)) ? bus.MW_ALUout : rs_raw;
        end
        if (rst && (bus.rt_addr != '0)) begin
            bus.rt_data = (commit && (bus.MW_RD == bus.rt_addr)) ? bus.MW_ALUout : rt_raw;
        end
    end

    // Echo captures every cycle; only the counter depends on the commit.
    always_comb begin
        wb_rd_d       = bus.MW_RD;
        wb_data_d     = bus.MW_ALUout;
        wb_regwrite_d = commit;
        wb_count_d    = commit ? (wb_count_q + 32'd1) : wb_count_q;
    end

    // Echo and retire counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_regwrite_q <= 1'b0;
            wb_count_q    <= '0;
        end else begin
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_count_q    <= wb_count_d;
        end
    end

    assign bus.WB_RD       = wb_rd_q;
    assign bus.WB_data     = wb_data_q;
    assign bus.WB_RegWrite = wb_regwrite_q;
    assign bus.wb_count    = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile. Stimulus pushes expected values into
// two queues: read/status checks (drained when the stimulus signals the
// outputs have settled) and expected commits (drained whenever the DUT
// presents WB_RegWrite on its echo).
module tb_writeback_regfile;

    logic clk = 1'b0;
    logic rst;
    logic clk_en = 1'b0;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    localparam int S_RS = 0, S_RT = 1, S_WBRD = 2, S_WBDATA = 3, S_WBRW = 4, S_CNT = 5;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } rchk_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } commit_t;

    rchk_t   rq[$];
    commit_t cq[$];
    event    chk_ev;
    int      n_tests = 0;
    int      n_fail  = 0;

    function automatic logic [31:0] dut_val(int sel);
        case (sel)
            S_RS:     return bus.rs_data;
            S_RT:     return bus.rt_data;
            S_WBRD:   return {27'd0, bus.WB_RD};
            S_WBDATA: return bus.WB_data;
            S_WBRW:   return {31'd0, bus.WB_RegWrite};
            default:  return bus.wb_count;
        endcase
    endfunction

    task automatic chk(string name, int sel, logic [31:0] exp);
        rchk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        rq.push_back(c);
    endtask

    task automatic flush();
        ->chk_ev;
        #1;
    endtask

    task automatic drive(logic [4:0] rd, logic [31:0] d, logic we, bit expect_commit);
        commit_t c;
        bus.MW_RD       = rd;
        bus.MW_ALUout   = d;
        bus.MW_RegWrite = we;
        if (expect_commit) begin
            c.rd   = rd;
            c.data = d;
            cq.push_back(c);
        end
    endtask

    task automatic idle();
        bus.MW_RD       = 5'd0;
        bus.MW_ALUout   = 32'd0;
        bus.MW_RegWrite = 1'b0;
    endtask

    // Read/status monitor: compares every queued expectation once outputs settle.
    initial begin
        forever begin
            rchk_t c;
            logic [31:0] act;
            @(chk_ev);
            while (rq.size() > 0) begin
                c   = rq.pop_front();
                act = dut_val(c.sel);
                n_tests++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
                end
            end
        end
    end

    // Echo monitor: each presented commit must match the oldest expected one.
    initial begin
        forever begin
            commit_t c;
            @(negedge clk);
            if (bus.WB_RegWrite === 1'b1) begin
                n_tests++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL echo_unexpected: got WB_RD=%0d WB_data=0x%08h expected no commit",
                             bus.WB_RD, bus.WB_data);
                end else begin
                    c = cq.pop_front();
                    if (bus.WB_RD !== c.rd || bus.WB_data !== c.data) begin
                        n_fail++;
                        $display("FAIL echo: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                                 bus.WB_RD, bus.WB_data, c.rd, c.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;

        // Reset with the clock stopped
        #3 rst = 1'b0;
        bus.rs_addr = 5'd7;
        #1;
        chk("rst_rs", S_RS, 32'd0);
        chk("rst_rt", S_RT, 32'd0);
        chk("rst_wbrd", S_WBRD, 32'd0);
        chk("rst_wbdata", S_WBDATA, 32'd0);
        chk("rst_wbrw", S_WBRW, 32'd0);
        chk("rst_cnt", S_CNT, 32'd0);
        flush();
        #5 rst = 1'b1;
        #2 clk_en = 1'b1;

        // Commit and read back
        @(negedge clk) drive(5'd5, 32'h1234ABCD, 1'b1, 1'b1);
        @(posedge clk) #1 idle();
        bus.rs_addr = 5'd5;
        #1;
        chk("wr_rs", S_RS, 32'h1234ABCD);
        chk("wr_cnt", S_CNT, 32'd1);
        chk("wr_wbrd", S_WBRD, 32'd5);
        chk("wr_wbdata", S_WBDATA, 32'h1234ABCD);
        chk("wr_wbrw", S_WBRW, 32'd1);
        flush();

        // Bypass on both ports in the same cycle
        @(negedge clk) drive(5'd9, 32'hDEADBEEF, 1'b1, 1'b1);
        bus.rs_addr = 5'd9;
        bus.rt_addr = 5'd9;
        #1;
        chk("byp_rs", S_RS, 32'hDEADBEEF);
        chk("byp_rt", S_RT, 32'hDEADBEEF);
        flush();
        @(posedge clk) #1 idle();
        bus.rt_addr = 5'd5;
        #1;
        chk("byp_rf_rs", S_RS, 32'hDEADBEEF);
        chk("byp_rf_rt", S_RT, 32'h1234ABCD);
        chk("byp_cnt", S_CNT, 32'd2);
        flush();

        // Bypass beats stale array contents
        @(negedge clk) drive(5'd5, 32'h00000055, 1'b1, 1'b1);
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd9;
        #1;
        chk("prio_rs", S_RS, 32'h00000055);
        chk("prio_rt", S_RT, 32'hDEADBEEF);
        flush();
        @(posedge clk) #1 idle();
        #1;
        chk("prio_rf_rs", S_RS, 32'h00000055);
        chk("prio_cnt", S_CNT, 32'd3);
        flush();

        // r0 guard
        @(negedge clk) drive(5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        #1;
        chk("r0_rs", S_RS, 32'd0);
        chk("r0_rt", S_RT, 32'd0);
        flush();
        @(posedge clk) #1;
        chk("r0_cnt", S_CNT, 32'd3);
        chk("r0_wbrw", S_WBRW, 32'd0);
        chk("r0_wbrd", S_WBRD, 32'd0);
        chk("r0_wbdata", S_WBDATA, 32'hFFFFFFFF);
        chk("r0_rs_after", S_RS, 32'd0);
        flush();
        idle();

        // Disabled write
        @(negedge clk) drive(5'd3, 32'h0000AAAA, 1'b0, 1'b0);
        bus.rt_addr = 5'd3;
        #1;
        chk("dis_rt", S_RT, 32'd0);
        flush();
        @(posedge clk) #1;
        chk("dis_rt_after", S_RT, 32'd0);
        chk("dis_cnt", S_CNT, 32'd3);
        chk("dis_wbrd", S_WBRD, 32'd3);
        chk("dis_wbrw", S_WBRW, 32'd0);
        flush();
        idle();

        // Back-to-back writes to one register
        @(negedge clk) drive(5'd7, 32'd1, 1'b1, 1'b1);
        bus.rs_addr = 5'd7;
        @(negedge clk) drive(5'd7, 32'd2, 1'b1, 1'b1);
        #1;
        chk("b2b_byp", S_RS, 32'd2);
        flush();
        @(posedge clk) #1 idle();
        #1;
        chk("b2b_rs", S_RS, 32'd2);
        chk("b2b_cnt", S_CNT, 32'd5);
        flush();

        // Counter wrap
        @(negedge clk) idle();
        force dut.wb_count_d = 32'hFFFFFFFF;
        @(posedge clk) #1 release dut.wb_count_d;
        #1;
        chk("wrap_pre", S_CNT, 32'hFFFFFFFF);
        flush();
        @(negedge clk) drive(5'd10, 32'h00000077, 1'b1, 1'b1);
        @(posedge clk) #1 idle();
        bus.rs_addr = 5'd10;
        #1;
        chk("wrap_cnt", S_CNT, 32'd0);
        chk("wrap_rs", S_RS, 32'h00000077);
        flush();

        // Reset between two writes to r4
        @(negedge clk) drive(5'd4, 32'h00001111, 1'b1, 1'b1);
        @(posedge clk) #1 idle();
        bus.rs_addr = 5'd4;
        #1;
        chk("mid_pre_rs", S_RS, 32'h00001111);
        chk("mid_pre_cnt", S_CNT, 32'd1);
        flush();
        @(negedge clk) #2 rst = 1'b0;
        #1;
        chk("mid_rst_rs", S_RS, 32'd0);
        chk("mid_rst_cnt", S_CNT, 32'd0);
        chk("mid_rst_wbrw", S_WBRW, 32'd0);
        chk("mid_rst_wbrd", S_WBRD, 32'd0);
        flush();
        drive(5'd4, 32'h00009999, 1'b1, 1'b0);
        @(posedge clk) #1;
        @(negedge clk) #2 idle();
        rst = 1'b1;
        #1;
        chk("mid_post_rs", S_RS, 32'd0);
        chk("mid_post_cnt", S_CNT, 32'd0);
        flush();
        @(negedge clk) drive(5'd4, 32'h00002222, 1'b1, 1'b1);
        @(posedge clk) #1 idle();
        #1;
        chk("mid_w2_rs", S_RS, 32'h00002222);
        chk("mid_w2_cnt", S_CNT, 32'd1);
        chk("mid_w2_wbrd", S_WBRD, 32'd4);
        chk("mid_w2_wbrw", S_WBRW, 32'd1);
        flush();

        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (cq.size() != 0) begin
            n_fail++;
            $display("FAIL echo_drain: got %0d pending commits expected 0", cq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Final stage of the five-stage pipeline: consumes the MEM/WB pipeline register (`MW_RD`, `MW_ALUout`, `MW_RegWrite`) and commits results into the 32×32 general-purpose register file. Provides the two decode-stage read ports, with same-cycle write-through bypass. Echoes the committed write one cycle later for WB→EX forwarding, and keeps a retire counter for debug and verification.

## Interface
Parameters:
- `DATA_W`, 32: register and data width
- `NREG`, 32: register count; address width is `log2(NREG)` = 5

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-low; `rst`=0 resets immediately, independent of `clk`
- `MW_RD`  in  5  destination register from the MEM/WB register
- `MW_ALUout`  in  32  result to write
- `MW_RegWrite`  in  1  write enable from the MEM/WB register
- `rs_addr`  in  5  decode read port A address
- `rt_addr`  in  5  decode read port B address
- `rs_data`  out  32  read port A data, combinational
- `rt_data`  out  32  read port B data, combinational
- `WB_RD`  out  5  registered copy of the committed destination
- `WB_data`  out  32  registered copy of the committed data
- `WB_RegWrite`  out  1  registered commit flag
- `wb_count`  out  32  count of committed writes

## Operation
- Commit condition: `commit = MW_RegWrite && (MW_RD != 0)`.
- On a rising edge with `commit`=1: `RF[MW_RD] <= MW_ALUout`.
- A write to r0 is dropped. r0 reads as 0 at all times.
- Read ports use this priority:
  1. Address is 0 → output 0.
  2. Otherwise, `commit` is 1 and `MW_RD` equals the address → output `MW_ALUout` (bypass).
  3. Otherwise → output `RF[addr]`.
- Both ports are independent. Both may hit the bypass in the same cycle.
- Echo registers, updated every rising edge:
  - `WB_RegWrite <= commit`
  - `WB_RD <= MW_RD`
  - `WB_data <= MW_ALUout`
- `wb_count` increments by 1 on each edge where `commit`=1. It wraps from 0xFFFFFFFF to 0 and never saturates.
- `MW_RegWrite`=0 leaves the register file and counter unchanged. Echo registers still capture their inputs, with `WB_RegWrite`=0.

## Timing
- While `rst`=0: all outputs are cleared asynchronously.
  - `RF[0..31]` = 0, so `rs_data`/`rt_data` read 0.
  - `WB_RD` = 0, `WB_data` = 0, `WB_RegWrite` = 0, `wb_count` = 0.
- Reset asserted mid-operation: a write presented in the same cycle is lost.
- First edge after `rst` rises: normal operation resumes.
- Write latency through the array: a value presented at edge N is readable from `RF` after edge N.
- Bypass makes the value visible on the read ports during cycle N itself, i.e. zero-cycle read-after-write.
- Echo latency is exactly 1 cycle: `WB_*` after edge N reflect the `MW_*` inputs sampled at edge N.
- No handshake and no backpressure. One write is accepted every cycle, unconditionally.
- Back-to-back writes to the same register: the later one wins. The bypass always shows the current cycle's `MW_ALUout`.

## Structure
- Shared pipeline package holds:
  - `REG_ADDR_W` = 5, `DATA_W` = 32
  - `REG_ZERO` = 5'd0
  - the MEM/WB bundle typedef (`rd`, `aluout`, `regwrite`), reused by the memory stage
- Sub-module `regfile_2r1w` holds the array, async clear, r0 masking and the two raw read ports.
- The top level adds the bypass mux, echo registers and counter.

## Test plan
- Reset: drive `rst`=0 mid-cycle with `clk` stopped → all outputs 0 immediately; `rs_addr`=7 reads 0.
- Commit and read: write r5=0x1234ABCD at edge N, then set `rs_addr`=5 → `rs_data`=0x1234ABCD; `wb_count`=1; `WB_RD`=5, `WB_RegWrite`=1 after edge N.
- Bypass: `MW_RD`=9, `MW_ALUout`=0xDEADBEEF, `MW_RegWrite`=1, `rs_addr`=`rt_addr`=9 in the same cycle → both ports read 0xDEADBEEF before the edge.
- r0 guard: write r0=0xFFFFFFFF → r0 still reads 0; `wb_count` unchanged; `WB_RegWrite`=0.
- Counter wrap: force `wb_count`=0xFFFFFFFF, commit one write → `wb_count`=0.
- Disabled write and reset mid-stream: `MW_RegWrite`=0 with `MW_RD`=3 → r3 unchanged. Then pulse `rst` low between two writes to r4 → r4 reads 0 after reset, and the second write lands normally.
